// File: rtl/rx_downsampler_iq.sv
// Runtime power-of-two I/Q decimator with pick/average modes, followed by
// round-half-up requantisation with saturation. I and Q run as two lanes sharing one frame counter.

module rx_ds_lane #(
  parameter int NBT_IN   = 8,
  parameter int NBT_OUT  = 8,
  parameter int MAX_LOG2 = 3,
  parameter int KW       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      acc_en,
  input  logic                      frame_start,
  input  logic                      load,
  input  logic                      mode,
  input  logic [KW-1:0]             k,
  input  logic signed [NBT_IN-1:0]  smp,
  output logic signed [NBT_OUT-1:0] y
);
  localparam int AW = NBT_IN + MAX_LOG2;
  localparam int S  = NBT_IN - NBT_OUT;

  logic signed [AW-1:0]      acc, total, smp_x;
  logic signed [AW:0]        rnd, avg_w;
  logic signed [NBT_IN-1:0]  avg, x;
  logic signed [NBT_OUT-1:0] y_nxt;

  assign smp_x = {{MAX_LOG2{smp[NBT_IN-1]}}, smp};
  // Running sum restarts with the first sample of a frame, so D = 1 is just the sample.
  assign total = frame_start ? smp_x : acc + smp_x;

  always_comb begin
    rnd = '0;
    if (k != '0) rnd = (AW+1)'(1) << (k - 1'b1);
  end

  assign avg_w = ($signed({total[AW-1], total}) + rnd) >>> k;
  assign avg   = NBT_IN'(avg_w);
  assign x     = mode ? avg : smp;

  if (S > 0) begin : g_rnd
    localparam logic signed [NBT_IN:0] HALF = (NBT_IN+1)'(1) << (S - 1);
    localparam logic signed [NBT_IN:0] MAXV = (NBT_IN+1)'((2 ** (NBT_OUT-1)) - 1);
    localparam logic signed [NBT_IN:0] MINV = (NBT_IN+1)'(-(2 ** (NBT_OUT-1)));
    logic signed [NBT_IN:0] xr;
    always_comb begin
      xr = ($signed({x[NBT_IN-1], x}) + HALF) >>> S;
      if (xr > MAXV)      y_nxt = NBT_OUT'(MAXV);
      else if (xr < MINV) y_nxt = NBT_OUT'(MINV);
      else                y_nxt = NBT_OUT'(xr);
    end
  end else begin : g_pass
    assign y_nxt = NBT_OUT'(x);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      y   <= '0;
    end else begin
      if (acc_en) acc <= total;
      if (load)   y   <= y_nxt;
    end
  end
endmodule

module rx_downsampler_iq #(
  parameter int NBT_IN   = 8,
  parameter int NBF_IN   = 7,
  parameter int NBT_OUT  = 8,
  parameter int NBF_OUT  = 7,
  parameter int MAX_LOG2 = 3,
  parameter int NB_LOG   = 2
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic signed [NBT_IN-1:0]  i_sym_I,
  input  logic signed [NBT_IN-1:0]  i_sym_Q,
  input  logic [NB_LOG-1:0]         i_dec_log2,
  input  logic [MAX_LOG2-1:0]       i_phase,
  input  logic                      i_mode,
  output logic signed [NBT_OUT-1:0] o_sym_I,
  output logic signed [NBT_OUT-1:0] o_sym_Q,
  output logic                      o_valid
);
  localparam int NUM_LANES = 2;
  localparam int KW        = $clog2(MAX_LOG2 + 1);

  if (NBT_OUT > NBT_IN || NBF_OUT != NBF_IN - (NBT_IN - NBT_OUT)) begin : g_bad_cfg
    $error("rx_downsampler_iq: inconsistent output format");
  end

  typedef struct packed {
    logic [KW-1:0]       k;
    logic [MAX_LOG2-1:0] phase;
    logic                mode;
  } cfg_t;

  cfg_t                act, cfg_in, cur;
  logic [MAX_LOG2-1:0] cnt, mask;
  logic                frame_start, last, pick, accept, fire;

  always_comb begin
    cfg_in.k     = (int'(i_dec_log2) > MAX_LOG2) ? KW'(MAX_LOG2) : KW'(i_dec_log2);
    cfg_in.phase = i_phase;
    cfg_in.mode  = i_mode;
  end

  // At frame start the live inputs steer this sample; afterwards the latched copy does.
  assign frame_start = (cnt == '0);
  assign cur         = frame_start ? cfg_in : act;
  assign mask        = ~({MAX_LOG2{1'b1}} << cur.k);
  assign last        = (cnt == mask);
  assign pick        = (cnt == (cur.phase & mask));
  assign accept      = i_enable & i_valid;
  assign fire        = accept & (cur.mode ? last : pick);

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      cnt     <= '0;
      act     <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= fire;
      if (accept) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (frame_start) act <= cfg_in;
      end
    end
  end

  logic [NUM_LANES-1:0][NBT_IN-1:0]  smp;
  logic [NUM_LANES-1:0][NBT_OUT-1:0] y;

  assign smp = {i_sym_Q, i_sym_I};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    rx_ds_lane #(
      .NBT_IN(NBT_IN), .NBT_OUT(NBT_OUT), .MAX_LOG2(MAX_LOG2), .KW(KW)
    ) u_lane (
      .clk         (clk),
      .rst         (i_reset),
      .acc_en      (accept),
      .frame_start (frame_start),
      .load        (fire),
      .mode        (cur.mode),
      .k           (cur.k),
      .smp         (smp[l]),
      .y           (y[l])
    );
  end

  assign o_sym_I = y[0];
  assign o_sym_Q = y[1];
endmodule

// File: tb/tb_rx_downsampler_iq.sv
// Scoreboard bench: an 8-bit-out instance for decimation/averaging and a 6-bit-out instance for requantisation.

module tb_rx_downsampler_iq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en_a, en_b, valid, mode;
  logic signed [7:0] sym_i, sym_q;
  logic [1:0]        dec;
  logic [2:0]        phase;
  logic signed [7:0] a_i, a_q;
  logic signed [5:0] b_i, b_q;
  logic              a_v, b_v;

  rx_downsampler_iq #(.NBT_IN(8), .NBF_IN(7), .NBT_OUT(8), .NBF_OUT(7), .MAX_LOG2(3), .NB_LOG(2)) dut_a (
    .clk(clk), .i_reset(rst), .i_enable(en_a), .i_valid(valid),
    .i_sym_I(sym_i), .i_sym_Q(sym_q), .i_dec_log2(dec), .i_phase(phase), .i_mode(mode),
    .o_sym_I(a_i), .o_sym_Q(a_q), .o_valid(a_v));

  rx_downsampler_iq #(.NBT_IN(8), .NBF_IN(7), .NBT_OUT(6), .NBF_OUT(5), .MAX_LOG2(3), .NB_LOG(2)) dut_b (
    .clk(clk), .i_reset(rst), .i_enable(en_b), .i_valid(valid),
    .i_sym_I(sym_i), .i_sym_Q(sym_q), .i_dec_log2(dec), .i_phase(phase), .i_mode(mode),
    .o_sym_I(b_i), .o_sym_Q(b_q), .o_valid(b_v));

  typedef struct { int i; int q; int c; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_v) begin
      n_vec++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL a_unexpected: got I=%0d Q=%0d at cycle %0d, required no output", a_i, a_q, cyc);
      end else begin
        e = qa.pop_front();
        if (int'(a_i) != e.i || int'(a_q) != e.q || cyc != e.c) begin
          n_err++;
          $display("FAIL a_out: got I=%0d Q=%0d cyc=%0d, required I=%0d Q=%0d cyc=%0d",
                   a_i, a_q, cyc, e.i, e.q, e.c);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_v) begin
      n_vec++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL b_unexpected: got I=%0d Q=%0d at cycle %0d, required no output", b_i, b_q, cyc);
      end else begin
        e = qb.pop_front();
        if (int'(b_i) != e.i || int'(b_q) != e.q || cyc != e.c) begin
          n_err++;
          $display("FAIL b_out: got I=%0d Q=%0d cyc=%0d, required I=%0d Q=%0d cyc=%0d",
                   b_i, b_q, cyc, e.i, e.q, e.c);
        end
      end
    end
  end

  // Inputs are applied at a falling edge and held through the next rising edge.
  task automatic step(input bit v, input int iv, input int qv,
                      input bit chk = 1'b0, input int ei = 0, input int eq = 0);
    valid = v;
    sym_i = 8'(iv);
    sym_q = 8'(qv);
    if (chk) begin
      if (en_a) qa.push_back('{ei, eq, cyc + 1});
      if (en_b) qb.push_back('{ei, eq, cyc + 1});
    end
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input int got_i, input int got_q, input int got_v);
    n_vec++;
    if (got_i != 0 || got_q != 0 || got_v != 0) begin
      n_err++;
      $display("FAIL %s: got I=%0d Q=%0d valid=%0d, required all 0", name, got_i, got_q, got_v);
    end
  endtask

  task automatic cfg(input int k, input int ph, input bit md);
    dec   = 2'(k);
    phase = 3'(ph);
    mode  = md;
  endtask

  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; valid = 1'b0;
    sym_i = '0; sym_q = '0; cfg(0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk_out("reset_a", int'(a_i), int'(a_q), int'(a_v));
    chk_out("reset_b", int'(b_i), int'(b_q), int'(b_v));
    rst = 1'b0;
    en_a = 1'b1;
    @(negedge clk);

    // pick, D=2, phase 0, continuous ramp: outputs 0,2,4,6
    cfg(1, 0, 1'b0);
    for (int n = 0; n < 8; n++) step(1'b1, n, 100 - n, (n % 2) == 0, n, 100 - n);
    step(1'b0, 0, 0);

    // pick, D=4, phase 3, valid every other cycle: outputs 3,7,11
    cfg(2, 3, 1'b0);
    for (int n = 0; n < 12; n++) begin
      step(1'b1, n, -n, (n % 4) == 3, n, -n);
      step(1'b0, 99, -99);
    end

    // average, D=4: 10..13 -> 12; -1,-1,-1,-2 -> -1
    cfg(2, 0, 1'b1);
    step(1'b1, 10, -1); step(1'b1, 11, -1); step(1'b1, 12, -1);
    step(1'b1, 13, -2, 1'b1, 12, -1);
    // full-scale averages stay in range
    for (int n = 0; n < 3; n++) step(1'b1, 127, -128);
    step(1'b1, 127, -128, 1'b1, 127, -128);
    step(1'b0, 0, 0);

    // average, D=8: 1..8 -> (36+4)>>3 = 5; -1,0.. -> 0
    cfg(3, 0, 1'b1);
    step(1'b1, 1, -1);
    for (int n = 2; n < 8; n++) step(1'b1, n, 0);
    step(1'b1, 8, 0, 1'b1, 5, 0);

    // D=1 in both modes; phase 5 masks to 0
    cfg(0, 0, 1'b1);
    step(1'b1, -5, 7, 1'b1, -5, 7);
    cfg(0, 5, 1'b0);
    step(1'b1, 9, -9, 1'b1, 9, -9);

    // average: k changes 1->2 at cnt=1, current frame stays D=2
    cfg(1, 0, 1'b1);
    step(1'b1, 4, 0);
    cfg(2, 0, 1'b1);
    step(1'b1, 6, 2, 1'b1, 5, 1);
    step(1'b1, 1, 0); step(1'b1, 2, 0); step(1'b1, 3, 0);
    step(1'b1, 4, 1, 1'b1, 3, 0);

    // enable low mid-frame freezes the frame
    step(1'b1, 20, 0); step(1'b1, 20, 0);
    en_a = 1'b0;
    repeat (3) step(1'b1, 77, -77);
    en_a = 1'b1;
    step(1'b1, 20, 0);
    step(1'b1, 24, 3, 1'b1, 21, 1);

    // reset at cnt=2 discards the partial frame
    step(1'b1, 8, 8); step(1'b1, 8, 8);
    valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_out("reset_mid", int'(a_i), int'(a_q), int'(a_v));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    step(1'b1, 4, -4); step(1'b1, 4, -4); step(1'b1, 4, -4);
    step(1'b1, 4, -4, 1'b1, 4, -4);
    step(1'b0, 0, 0);

    // 6-bit output: round-half-up and saturation
    en_a = 1'b0;
    en_b = 1'b1;
    cfg(0, 0, 1'b0);
    step(1'b1, 127, -128, 1'b1, 31, -32);
    step(1'b1, 5, 6, 1'b1, 1, 2);
    step(1'b1, -3, -2, 1'b1, -1, 0);
    step(1'b1, 125, 126, 1'b1, 31, 31);
    step(1'b1, 126, -127, 1'b1, 31, -32);
    step(1'b0, 0, 0);

    for (int n = 0; n < 20 && (qa.size() != 0 || qb.size() != 0); n++) @(negedge clk);
    while (qa.size() != 0) begin
      exp_t e = qa.pop_front();
      n_vec++; n_err++;
      $display("FAIL a_missing: got no output, required I=%0d Q=%0d cyc=%0d", e.i, e.q, e.c);
    end
    while (qb.size() != 0) begin
      exp_t e = qb.pop_front();
      n_vec++; n_err++;
      $display("FAIL b_missing: got no output, required I=%0d Q=%0d cyc=%0d", e.i, e.q, e.c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rx_downsampler_iq.md
# rx_downsampler_iq

Parametrised I/Q downsampler for the receive path, placed after the anti-alias filter. It replaces the fixed rate-2 decimation with a runtime power-of-two factor, a selectable sampling phase and an integrate-and-dump averaging mode. Output precision is reduced with round-half-up and saturation. The block drives a registered output with a single-cycle valid strobe toward the downstream receive chain.

## Interface
- NBT_IN, 8, total bits of input samples (signed).
- NBF_IN, 7, fractional bits of input samples.
- NBT_OUT, 8, total bits of output samples; must satisfy NBT_OUT ≤ NBT_IN.
- NBF_OUT, 7, fractional bits of output; fixed at NBF_IN − (NBT_IN − NBT_OUT).
- MAX_LOG2, 3, log2 of the maximum decimation factor (D_max = 8).
- NB_LOG, 2, width of i_dec_log2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  global enable; when 0, all state holds and o_valid = 0.
- i_valid  in  1  input sample strobe; a sample is accepted when i_enable & i_valid.
- i_sym_I, i_sym_Q  in  NBT_IN  signed I/Q input samples.
- i_dec_log2  in  NB_LOG  decimation factor D = 2^k; values above MAX_LOG2 clamp to MAX_LOG2.
- i_phase  in  MAX_LOG2  pick-mode sample phase; masked with D−1.
- i_mode  in  1  0 = pick one sample per frame, 1 = average D samples.
- o_sym_I, o_sym_Q  out  NBT_OUT  signed decimated samples.
- o_valid  out  1  single-cycle pulse; high when a new output is presented.

## Operation
- Frame counter cnt runs 0..D−1.
  - Increments on each accepted sample.
  - Wraps from D−1 to 0.
  - Holds when no sample is accepted.
- Configuration {k, phase, mode} is latched into active registers on the sample accepted at cnt = 0.
  - In that same cycle, decisions use the input values directly.
  - In all other cycles, decisions use the active registers.
  - A change mid-frame therefore takes effect at the next frame start.
- Pick mode:
  - On the accepted sample with cnt = phase & (D−1), the I and Q samples enter the output stage.
- Average mode:
  - Per-channel accumulator, NBT_IN + MAX_LOG2 bits, signed.
  - acc ← sample at cnt = 0; acc ← acc + sample otherwise.
  - On cnt = D−1: total = acc + sample (for D = 1, total = sample).
  - Average = (total + 2^(k−1)) >>> k when k > 0, else total. This is arithmetic shift with round-half-up, and the result always fits in NBT_IN bits.
- Output stage, common to both modes. Let s = NBT_IN − NBT_OUT.
  - If s > 0: y = (x + 2^(s−1)) >>> s, then saturate to [−2^(NBT_OUT−1), 2^(NBT_OUT−1)−1].
  - If s = 0: y = x.
- D = 1: every accepted sample is output. Both modes give identical results.
- I and Q share the counter and configuration; they always produce outputs in the same cycle.

## Timing
- Reset (async, immediate):
  - cnt = 0, acc = 0.
  - Active config = {k = 0, phase = 0, mode = 0}.
  - o_sym_I = o_sym_Q = 0, o_valid = 0.
- Latency: o_valid and the new o_sym_* appear on the clock edge that accepts the completing sample. They are visible in the following cycle, i.e. 1-cycle latency.
- o_valid is high for exactly one cycle per completed frame. o_sym_* hold their value between pulses.
- i_enable = 0 mid-frame: cnt, acc, active config and outputs freeze; o_valid = 0. The frame resumes when i_enable returns high.
- Gaps in i_valid lengthen the frame without corrupting it.
- Reset mid-frame: the partial frame is discarded. The first sample accepted after deassertion is treated as cnt = 0.
- Maximum throughput: one input per cycle; one output every D accepted samples.

## Test plan
- Pick mode, k = 1, phase = 0, i_valid = 1 continuously, I ramp 0,1,2,…: o_valid every 2nd cycle with o_sym_I = 0,2,4,…, each appearing 1 cycle after its sample.
- Pick mode, k = 2, phase = 3, I ramp from 0, with i_valid toggling every other cycle: o_sym_I = 3,7,11; exactly one pulse per 4 accepted samples; no output during gaps.
- Average mode, k = 2:
  - I = 10,11,12,13 → o_sym_I = 12.
  - Q = −1,−1,−1,−2 → o_sym_Q = −1.
  - o_valid one cycle after the 4th sample.
- Variant NBT_OUT = 6, NBF_OUT = 5, pick mode, k = 0:
  - Input 127 → 31 (saturated).
  - Input −128 → −32.
  - Input 5 → 1.
  - Input 6 → 2.
- Config change at cnt = 1 from k = 1 to k = 2 in average mode: the current frame completes with D = 2; the next frame uses D = 4.
- Assert i_reset at cnt = 2 of a D = 4 average frame: outputs become 0 immediately. After release, inputs 4,4,4,4 produce o_sym_I = 4 after exactly 4 accepted samples.
